// File: rtl/lamp_cmd_sequencer.sv
// Lamp command sequencer: buffers lamp requests in a small FIFO and plays them out
// on the one-hot tcode/ulight/lenght bus, each held for a set time plus an idle gap.
module lamp_cmd_sequencer #(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [1:0]                 req_op,
  input  logic [3:0]                 req_ulight,
  input  logic [3:0]                 req_lenght,
  input  logic [7:0]                 req_hold,
  input  logic                       flush,
  output logic [3:0]                 tcode,
  output logic [3:0]                 ulight,
  output logic [3:0]                 lenght,
  output logic                       cmd_start,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int GW = $clog2(GAP_CYCLES + 2);
  localparam int EW = 18;

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;
  state_t state_reg, state_next;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [7:0]    hold_cnt_reg, hold_cnt_next;
  logic [GW-1:0] gap_cnt_reg, gap_cnt_next;
  logic [3:0]    tcode_reg, tcode_next;
  logic [3:0]    ulight_reg, ulight_next;
  logic [3:0]    lenght_reg, lenght_next;
  logic          start_reg, start_next;
  logic          push, pop, empty, load, clear;
  logic [1:0]    head_op;
  logic [3:0]    head_ulight, head_lenght, head_onehot;
  logic [7:0]    head_hold;

  // Readiness ignores a same-cycle pop, so a full FIFO always refuses.
  assign req_ready = rst_n && !flush && (count_reg < CW'(DEPTH));
  assign push      = req_valid && req_ready;
  assign empty     = (count_reg == '0);
  assign {head_op, head_ulight, head_lenght, head_hold} = mem[rd_ptr_reg];

  for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
    assign head_onehot[gi] = (head_op == 2'(gi));
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {req_op, req_ulight, req_lenght, req_hold};
    end
  end

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    gap_cnt_next  = gap_cnt_reg;
    tcode_next    = tcode_reg;
    ulight_next   = ulight_reg;
    lenght_next   = lenght_reg;
    start_next    = 1'b0;
    pop           = 1'b0;
    load          = 1'b0;
    clear         = 1'b0;

    if (flush) begin
      state_next = IDLE;
      clear      = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!empty) load = 1'b1;
        end
        DRIVE: begin
          if (hold_cnt_reg == 8'd1) begin
            if (GAP_CYCLES > 0) begin
              state_next   = GAP;
              gap_cnt_next = GW'(GAP_CYCLES);
              clear        = 1'b1;
            end else if (!empty) begin
              load = 1'b1;
            end else begin
              state_next = IDLE;
              clear      = 1'b1;
            end
          end else begin
            hold_cnt_next = hold_cnt_reg - 8'd1;
          end
        end
        GAP: begin
          if (gap_cnt_reg == GW'(1)) begin
            if (!empty) load = 1'b1;
            else        state_next = IDLE;
          end else begin
            gap_cnt_next = gap_cnt_reg - GW'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end

    // Loading pops the head entry straight onto the bus for the next cycle.
    if (load) begin
      pop           = 1'b1;
      state_next    = DRIVE;
      start_next    = 1'b1;
      tcode_next    = head_onehot;
      ulight_next   = head_ulight;
      lenght_next   = head_lenght;
      hold_cnt_next = (head_hold == 8'd0) ? 8'd1 : head_hold;
    end
    if (clear) begin
      tcode_next  = 4'd0;
      ulight_next = 4'd0;
      lenght_next = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      hold_cnt_reg <= 8'd0;
      gap_cnt_reg  <= '0;
      tcode_reg    <= 4'd0;
      ulight_reg   <= 4'd0;
      lenght_reg   <= 4'd0;
      start_reg    <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
      tcode_reg    <= tcode_next;
      ulight_reg   <= ulight_next;
      lenght_reg   <= lenght_next;
      start_reg    <= start_next;
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
        if (push && !pop)      count_reg <= count_reg + CW'(1);
        else if (pop && !push) count_reg <= count_reg - CW'(1);
      end
    end
  end

  assign tcode      = tcode_reg;
  assign ulight     = ulight_reg;
  assign lenght     = lenght_reg;
  assign cmd_start  = start_reg;
  assign busy       = !empty || (state_reg != IDLE);
  assign fifo_count = count_reg;

endmodule

// File: tb/tb_lamp_cmd_sequencer.sv
// Self-checking bench for lamp_cmd_sequencer: one instance with a one-cycle gap and one
// without, both compared against a queue-based schedule model every cycle.
module tb_lamp_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n;
  logic req_valid, flush;
  logic [1:0] req_op;
  logic [3:0] req_ulight, req_lenght;
  logic [7:0] req_hold;

  logic          dut_ready [2];
  logic [3:0]    dut_tcode [2];
  logic [3:0]    dut_ulight [2];
  logic [3:0]    dut_lenght [2];
  logic          dut_start [2];
  logic          dut_busy [2];
  logic [CW-1:0] dut_count [2];

  always #5 clk = ~clk;

  lamp_cmd_sequencer #(.DEPTH(DEPTH), .GAP_CYCLES(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(dut_ready[0]),
    .req_op(req_op), .req_ulight(req_ulight), .req_lenght(req_lenght), .req_hold(req_hold),
    .flush(flush), .tcode(dut_tcode[0]), .ulight(dut_ulight[0]), .lenght(dut_lenght[0]),
    .cmd_start(dut_start[0]), .busy(dut_busy[0]), .fifo_count(dut_count[0])
  );

  lamp_cmd_sequencer #(.DEPTH(DEPTH), .GAP_CYCLES(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(dut_ready[1]),
    .req_op(req_op), .req_ulight(req_ulight), .req_lenght(req_lenght), .req_hold(req_hold),
    .flush(flush), .tcode(dut_tcode[1]), .ulight(dut_ulight[1]), .lenght(dut_lenght[1]),
    .cmd_start(dut_start[1]), .busy(dut_busy[1]), .fifo_count(dut_count[1])
  );

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] ul;
    logic [3:0] len;
    logic [7:0] hold;
  } ent_t;

  typedef struct packed {
    logic [3:0] tc;
    logic [3:0] ul;
    logic [3:0] len;
    logic       st;
  } cyc_t;

  typedef struct {
    int v, op, ul, len, hold, fl;
    int tc, eul, elen, st, busy, cnt;
  } vec_t;

  // Model: pending requests, and the bus contents of every committed future cycle.
  ent_t mq [2][$];
  cyc_t ms [2][$];

  int checks = 0;
  int failures = 0;
  int acc, n, ncol, starts;
  logic [19:0] stream;
  logic [15:0] got;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [3:0] ul,
                       input logic [3:0] len, input logic [7:0] hold, input logic fl);
    req_valid  = v;
    req_op     = op;
    req_ulight = ul;
    req_lenght = len;
    req_hold   = hold;
    flush      = fl;
  endtask

  task automatic sample_check();
    cyc_t c;
    logic exp_busy, exp_ready;
    for (int d = 0; d < 2; d++) begin
      c = '0;
      if (ms[d].size() > 0) c = ms[d][0];
      exp_busy  = (mq[d].size() > 0) || (ms[d].size() > 0);
      exp_ready = rst_n && !flush && (mq[d].size() < DEPTH);
      chk($sformatf("tcode%0d", d), 32'(dut_tcode[d]), 32'(c.tc));
      chk($sformatf("ulight%0d", d), 32'(dut_ulight[d]), 32'(c.ul));
      chk($sformatf("lenght%0d", d), 32'(dut_lenght[d]), 32'(c.len));
      chk($sformatf("cmd_start%0d", d), 32'(dut_start[d]), 32'(c.st));
      chk($sformatf("busy%0d", d), 32'(dut_busy[d]), 32'(exp_busy));
      chk($sformatf("fifo_count%0d", d), 32'(dut_count[d]), 32'(mq[d].size()));
      chk($sformatf("req_ready%0d", d), 32'(dut_ready[d]), 32'(exp_ready));
      if (d == 0 && req_valid && exp_ready)
        $display("push op=%0d ulight=%h lenght=%h hold=%0d t=%0t",
                 req_op, req_ulight, req_lenght, req_hold, $time);
    end
  endtask

  task automatic model_edge(input int d, input ent_t e);
    logic rdy;
    ent_t h;
    cyc_t c;
    int cycles;
    rdy = (mq[d].size() < DEPTH);
    if (flush) begin
      mq[d].delete();
      ms[d].delete();
    end else begin
      if (ms[d].size() > 0) void'(ms[d].pop_front());
      // The next command starts as soon as the previous command-plus-gap window is over.
      if (ms[d].size() == 0 && mq[d].size() > 0) begin
        h = mq[d].pop_front();
        cycles = (h.hold == 8'd0) ? 1 : int'(h.hold);
        for (int i = 0; i < cycles; i++) begin
          c.tc  = 4'b0001 << h.op;
          c.ul  = h.ul;
          c.len = h.len;
          c.st  = (i == 0);
          ms[d].push_back(c);
        end
        for (int i = 0; i < ((d == 0) ? 1 : 0); i++) ms[d].push_back(cyc_t'(0));
      end
      if (req_valid && rdy) mq[d].push_back(e);
    end
  endtask

  task automatic advance();
    ent_t e;
    e = {req_op, req_ulight, req_lenght, req_hold};
    for (int d = 0; d < 2; d++) model_edge(d, e);
  endtask

  task automatic step(input logic v, input logic [1:0] op, input logic [3:0] ul,
                      input logic [3:0] len, input logic [7:0] hold, input logic fl);
    drive(v, op, ul, len, hold, fl);
    @(negedge clk);
    sample_check();
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 2'd0, 4'd0, 4'd0, 8'd0, 1'b0);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((dut_busy[0] || dut_busy[1]) && k < 200) begin
      idle_step();
      k++;
    end
    chk("idle_timeout", 32'(dut_busy[0] | dut_busy[1]), 32'd0);
  endtask

  initial begin
    //          v op  ul  len hold fl   tc  ul  len st busy cnt
    tbl[0]  = '{1, 2, 'hA, 6, 3, 0,   0, 0,   0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0,   0, 0, 0,   0, 0,   0, 0, 1, 1};
    tbl[2]  = '{0, 0, 0,   0, 0, 0,   4, 'hA, 6, 1, 1, 0};
    tbl[3]  = '{0, 0, 0,   0, 0, 0,   4, 'hA, 6, 0, 1, 0};
    tbl[4]  = '{0, 0, 0,   0, 0, 0,   4, 'hA, 6, 0, 1, 0};
    tbl[5]  = '{0, 0, 0,   0, 0, 0,   0, 0,   0, 0, 1, 0};
    tbl[6]  = '{0, 0, 0,   0, 0, 0,   0, 0,   0, 0, 0, 0};
    tbl[7]  = '{1, 0, 'hF, 1, 0, 0,   0, 0,   0, 0, 0, 0};
    tbl[8]  = '{0, 0, 0,   0, 0, 0,   0, 0,   0, 0, 1, 1};
    tbl[9]  = '{0, 0, 0,   0, 0, 0,   1, 'hF, 1, 1, 1, 0};
    tbl[10] = '{0, 0, 0,   0, 0, 0,   0, 0,   0, 0, 1, 0};
    tbl[11] = '{0, 0, 0,   0, 0, 0,   0, 0,   0, 0, 0, 0};

    rst_n = 1'b0;
    drive(1'b0, 2'd0, 4'd0, 4'd0, 8'd0, 1'b0);
    repeat (2) begin
      @(negedge clk);
      sample_check();
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single requests: hold=3 then hold=0 on the gap-of-one instance.
    for (int i = 0; i < 12; i++) begin
      drive(1'(tbl[i].v), 2'(tbl[i].op), 4'(tbl[i].ul), 4'(tbl[i].len),
            8'(tbl[i].hold), 1'(tbl[i].fl));
      @(negedge clk);
      sample_check();
      chk($sformatf("tbl%0d_tcode", i), 32'(dut_tcode[0]), 32'(tbl[i].tc));
      chk($sformatf("tbl%0d_ulight", i), 32'(dut_ulight[0]), 32'(tbl[i].eul));
      chk($sformatf("tbl%0d_lenght", i), 32'(dut_lenght[0]), 32'(tbl[i].elen));
      chk($sformatf("tbl%0d_start", i), 32'(dut_start[0]), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_busy", i), 32'(dut_busy[0]), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_count", i), 32'(dut_count[0]), 32'(tbl[i].cnt));
      @(posedge clk);
      advance();
      #1;
    end
    wait_idle();

    // Back-to-back on the gapless instance: 0001,0001,0010,0010 then idle.
    step(1'b1, 2'd0, 4'h1, 4'h2, 8'd2, 1'b0);
    step(1'b1, 2'd1, 4'h3, 4'h4, 8'd2, 1'b0);
    stream = {16'd0, dut_tcode[1]};
    starts = int'(dut_start[1]);
    for (int i = 0; i < 4; i++) begin
      idle_step();
      stream = {stream[15:0], dut_tcode[1]};
      starts += int'(dut_start[1]);
    end
    chk("gap0_stream", 32'(stream), 32'h11220);
    chk("gap0_starts", 32'(starts), 32'd2);
    wait_idle();

    // Fill while a long command is on the bus.
    step(1'b1, 2'd3, 4'h5, 4'h5, 8'd30, 1'b0);
    idle_step();
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'(i), 4'(i), 4'(i + 1), 8'd1, 1'b0);
      @(negedge clk);
      sample_check();
      if (dut_ready[0]) acc++;
      @(posedge clk);
      advance();
      #1;
    end
    chk("fill_accepted", 32'(acc), 32'd4);
    chk("fill_count", 32'(dut_count[0]), 32'd4);
    chk("fill_ready", 32'(dut_ready[0]), 32'd0);
    got = 16'd0;
    ncol = 0;
    n = 0;
    while (ncol < 4 && n < 300) begin
      idle_step();
      if (dut_start[0]) begin
        got = {got[11:0], dut_tcode[0]};
        ncol++;
      end
      n++;
    end
    chk("fill_order", 32'(got), 32'h1248);
    wait_idle();

    // Flush during DRIVE with two entries queued and a same-cycle request.
    step(1'b1, 2'd1, 4'h1, 4'h1, 8'd10, 1'b0);
    step(1'b1, 2'd2, 4'h2, 4'h2, 8'd10, 1'b0);
    step(1'b1, 2'd3, 4'h3, 4'h3, 8'd10, 1'b0);
    chk("pre_flush_count", 32'(dut_count[0]), 32'd2);
    chk("pre_flush_tcode", 32'(dut_tcode[0]), 32'h2);
    step(1'b1, 2'd0, 4'hF, 4'hF, 8'd5, 1'b1);
    chk("flush_tcode", 32'(dut_tcode[0]), 32'd0);
    chk("flush_count", 32'(dut_count[0]), 32'd0);
    chk("flush_busy", 32'(dut_busy[0]), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 9) < 4), 2'($urandom_range(0, 3)), 4'($urandom),
           4'($urandom), 8'($urandom_range(0, 5)), 1'($urandom_range(0, 39) == 0));
    end
    step(1'b0, 2'd0, 4'd0, 4'd0, 8'd0, 1'b1);

    // Asynchronous reset in the middle of a command.
    step(1'b1, 2'd1, 4'h9, 4'h3, 8'd20, 1'b0);
    n = 0;
    while (dut_tcode[0] == 4'd0 && n < 10) begin
      idle_step();
      n++;
    end
    chk("rst_pre_tcode", 32'(dut_tcode[0]), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_tcode%0d", d), 32'(dut_tcode[d]), 32'd0);
      chk($sformatf("rst_ulight%0d", d), 32'(dut_ulight[d]), 32'd0);
      chk($sformatf("rst_lenght%0d", d), 32'(dut_lenght[d]), 32'd0);
      chk($sformatf("rst_start%0d", d), 32'(dut_start[d]), 32'd0);
      chk($sformatf("rst_busy%0d", d), 32'(dut_busy[d]), 32'd0);
      chk($sformatf("rst_count%0d", d), 32'(dut_count[d]), 32'd0);
      mq[d].delete();
      ms[d].delete();
    end
    @(negedge clk);
    sample_check();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (4) idle_step();
    step(1'b1, 2'd2, 4'h6, 4'h7, 8'd2, 1'b0);
    repeat (6) idle_step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
